// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch/control/status bundle between the PC sequencer and the CPU datapath
//
// Signal groups:
//   fetch   : imem_req (seq -> mem), imem_ack (mem -> seq), pc (seq -> mem/datapath)
//   control : LT, br_en, br_offset, jmp_en, call_en, ret_en, jmp_addr (datapath -> seq)
//   status  : exec, stk_ovf, stk_unf (seq -> datapath)
// The sequencer is the master: it requests fetches and drives the PC.
interface pc_sequencer_if #(
    parameter int n = 8
);
    logic         imem_req;
    logic         imem_ack;
    logic         LT;
    logic         br_en;
    logic [n-1:0] br_offset;
    logic         jmp_en;
    logic         call_en;
    logic         ret_en;
    logic [n-1:0] jmp_addr;
    logic         exec;
    logic [n-1:0] pc;
    logic         stk_ovf;
    logic         stk_unf;

    modport master (
        input  imem_ack, LT, br_en, br_offset, jmp_en, call_en, ret_en, jmp_addr,
        output imem_req, exec, pc, stk_ovf, stk_unf
    );

    modport slave (
        output imem_ack, LT, br_en, br_offset, jmp_en, call_en, ret_en, jmp_addr,
        input  imem_req, exec, pc, stk_ovf, stk_unf
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with fetch handshake and return-address stack
//
// Ports:
//   clock  : rising-edge clock
//   nReset : asynchronous active-low reset
//   bus    : pc_sequencer_if.master (fetch handshake, control inputs, pc and status outputs)
// Parameters:
//   n     : PC / address width
//   DEPTH : return-address stack entries (>= 2)
module pc_sequencer #(
    parameter int n     = 8,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            nReset,
    pc_sequencer_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [n-1:0]  ONE  = n'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [n-1:0]   pc_q, pc_d, pc_inc;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [n-1:0]   ras_q [DEPTH];
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic           push_en;
    logic           ras_empty, ras_full;
    logic [AW-1:0]  top_idx, push_idx;

    assign pc_inc    = pc_q + ONE;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULL);
    // top_idx is only used when the stack is non-empty; push_idx only when not full.
    assign top_idx   = AW'(cnt_q - 1'b1);
    assign push_idx  = AW'(cnt_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                // Exactly one action per instruction, highest priority first.
                if (bus.ret_en) begin
                    if (!ras_empty) begin
                        pc_d  = ras_q[top_idx];
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end
                end else if (bus.call_en) begin
                    pc_d = bus.jmp_addr;
                    if (!ras_full) begin
                        push_en = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (bus.jmp_en) begin
                    pc_d = bus.jmp_addr;
                end else if (bus.br_en && bus.LT) begin
                    pc_d = pc_q + bus.br_offset;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (push_en) begin
                ras_q[push_idx] <= pc_inc;
            end
        end
    end

    // All outputs come straight from registers: no input-to-output path.
    assign bus.imem_req = (state_q == FETCH);
    assign bus.exec     = (state_q == EXEC);
    assign bus.pc       = pc_q;
    assign bus.stk_ovf  = ovf_q;
    assign bus.stk_unf  = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
    logic clock;
    logic nReset;
    int   n_checks;
    int   n_errors;

    pc_sequencer_if #(.n(8)) bus ();

    pc_sequencer #(.n(8), .DEPTH(4)) dut (
        .clock  (clock),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_ctl();
        bus.ret_en    = 1'b0;
        bus.call_en   = 1'b0;
        bus.jmp_en    = 1'b0;
        bus.br_en     = 1'b0;
        bus.LT        = 1'b0;
        bus.br_offset = 8'h00;
        bus.jmp_addr  = 8'h00;
    endtask

    // Waits (bounded) for an EXEC cycle, applies controls in it, checks the pc in the following FETCH.
    task automatic instr(input string tag, input logic r, input logic c, input logic j,
                         input logic b, input logic lt, input logic [7:0] off,
                         input logic [7:0] addr, input logic [7:0] exp_pc);
        int k;
        k = 0;
        while (!bus.exec && k < 50) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_exec"}, 32'(bus.exec), 32'd1);
        bus.ret_en    = r;
        bus.call_en   = c;
        bus.jmp_en    = j;
        bus.br_en     = b;
        bus.LT        = lt;
        bus.br_offset = off;
        bus.jmp_addr  = addr;
        @(negedge clock);
        clear_ctl();
        check(tag, 32'(bus.pc), 32'(exp_pc));
    endtask

    initial begin
        clock        = 1'b0;
        nReset       = 1'b0;
        n_checks     = 0;
        n_errors     = 0;
        bus.imem_ack = 1'b1;
        clear_ctl();

        // Reset state and sequential fetch
        repeat (2) @(negedge clock);
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_exec", 32'(bus.exec), 32'd0);
        check("rst_ovf", 32'(bus.stk_ovf), 32'd0);
        check("rst_unf", 32'(bus.stk_unf), 32'd0);
        nReset = 1'b1;
        @(negedge clock);
        check("cyc1_req", 32'(bus.imem_req), 32'd1);
        check("cyc1_exec", 32'(bus.exec), 32'd0);
        check("cyc1_pc", 32'(bus.pc), 32'h0);
        @(negedge clock);
        check("cyc2_exec", 32'(bus.exec), 32'd1);
        instr("seq1", 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01);
        instr("seq2", 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h02);
        instr("seq3", 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h03);

        // Fetch stall: three FETCH edges with ack low
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_req", 32'(bus.imem_req), 32'd1);
            check("stall_exec", 32'(bus.exec), 32'd0);
            check("stall_pc", 32'(bus.pc), 32'h3);
        end
        bus.imem_ack = 1'b1;
        @(negedge clock);
        check("stall_done_exec", 32'(bus.exec), 32'd1);
        check("stall_done_pc", 32'(bus.pc), 32'h3);
        instr("seq4", 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h04);

        // Branches and wrap
        instr("jmp10a", 0, 0, 1, 0, 0, 8'h00, 8'h10, 8'h10);
        instr("br_taken", 0, 0, 0, 1, 1, 8'hFC, 8'h00, 8'h0C);
        instr("jmp10b", 0, 0, 1, 0, 0, 8'h00, 8'h10, 8'h10);
        instr("br_not_taken", 0, 0, 0, 1, 0, 8'hFC, 8'h00, 8'h11);
        instr("jmpff", 0, 0, 1, 0, 0, 8'h00, 8'hFF, 8'hFF);
        instr("wrap", 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);

        // Call/return nesting
        instr("jmp05", 0, 0, 1, 0, 0, 8'h00, 8'h05, 8'h05);
        instr("call40", 0, 1, 0, 0, 0, 8'h00, 8'h40, 8'h40);
        instr("call80", 0, 1, 0, 0, 0, 8'h00, 8'h80, 8'h80);
        instr("ret41", 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h41);
        instr("ret06", 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h06);

        // Priority: ret beats everything, and the call must not push
        instr("jmp20", 0, 0, 1, 0, 0, 8'h00, 8'h20, 8'h20);
        instr("call60", 0, 1, 0, 0, 0, 8'h00, 8'h60, 8'h60);
        instr("prio_all", 1, 1, 1, 1, 1, 8'h05, 8'h70, 8'h21);
        check("prio_ovf", 32'(bus.stk_ovf), 32'd0);
        check("prio_unf", 32'(bus.stk_unf), 32'd0);
        instr("prio_empty_ret", 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h22);
        check("prio_unf_set", 32'(bus.stk_unf), 32'd1);

        // Reset asserted in the middle of EXEC
        instr("call33", 0, 1, 0, 0, 0, 8'h00, 8'h33, 8'h33);
        for (int k = 0; k < 50 && !bus.exec; k++) @(negedge clock);
        check("midrst_in_exec", 32'(bus.exec), 32'd1);
        bus.jmp_en   = 1'b1;
        bus.jmp_addr = 8'h99;
        #2;
        nReset = 1'b0;
        #1;
        check("midrst_pc", 32'(bus.pc), 32'h0);
        check("midrst_exec", 32'(bus.exec), 32'd0);
        check("midrst_req", 32'(bus.imem_req), 32'd0);
        check("midrst_unf", 32'(bus.stk_unf), 32'd0);
        check("midrst_ovf", 32'(bus.stk_ovf), 32'd0);
        clear_ctl();
        @(negedge clock);
        nReset = 1'b1;
        instr("midrst_ret_empty", 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01);
        check("midrst_ret_unf", 32'(bus.stk_unf), 32'd1);

        // Overflow and underflow with DEPTH=4
        nReset = 1'b0;
        @(negedge clock);
        check("rst2_unf", 32'(bus.stk_unf), 32'd0);
        nReset = 1'b1;
        instr("ovf_call1", 0, 1, 0, 0, 0, 8'h00, 8'h10, 8'h10);
        instr("ovf_call2", 0, 1, 0, 0, 0, 8'h00, 8'h20, 8'h20);
        instr("ovf_call3", 0, 1, 0, 0, 0, 8'h00, 8'h30, 8'h30);
        instr("ovf_call4", 0, 1, 0, 0, 0, 8'h00, 8'h40, 8'h40);
        check("ovf_before", 32'(bus.stk_ovf), 32'd0);
        instr("ovf_call5", 0, 1, 0, 0, 0, 8'h00, 8'h50, 8'h50);
        check("ovf_after", 32'(bus.stk_ovf), 32'd1);
        instr("unf_ret1", 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h31);
        instr("unf_ret2", 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h21);
        instr("unf_ret3", 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11);
        instr("unf_ret4", 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01);
        check("unf_before", 32'(bus.stk_unf), 32'd0);
        instr("unf_ret5", 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h02);
        check("unf_after", 32'(bus.stk_unf), 32'd1);
        instr("sticky_step", 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h03);
        check("sticky_ovf", 32'(bus.stk_ovf), 32'd1);
        check("sticky_unf", 32'(bus.stk_unf), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that consumes the branch comparator's `LT` flag. It owns the PC register and a handshaked instruction-fetch request, and applies branch, jump, call and return decisions once per instruction. It includes a small hardware return-address stack (RAS) for call and return. It sits between the instruction memory and the decode/compare datapath of the CPU.

## Interface

**Parameters**
- `n`, default 8: PC and address width.
- `DEPTH`, default 4: number of RAS entries. Must be at least 2.

**Ports**
- `clock` input 1: single clock. Rising edge active.
- `nReset` input 1: reset, asynchronous assert, active-low. Deassertion is synchronous to `clock` upstream.
- `imem_ack` input 1: instruction memory has returned the word at `pc`.
- `LT` input 1: comparator result, Rdata1 < Rdata2 (unsigned).
- `br_en` input 1: conditional branch. Taken iff `LT` = 1.
- `br_offset` input n: two's-complement PC-relative offset.
- `jmp_en` input 1: unconditional jump to `jmp_addr`.
- `call_en` input 1: push return address, then jump to `jmp_addr`.
- `ret_en` input 1: pop the RAS into the PC.
- `jmp_addr` input n: absolute target for jump and call.
- `imem_req` output 1: fetch request for address `pc`.
- `exec` output 1: high in the single cycle in which control inputs are sampled.
- `pc` output n: current program counter.
- `stk_ovf` output 1: sticky flag, a push was attempted while the RAS was full.
- `stk_unf` output 1: sticky flag, a pop was attempted while the RAS was empty.

## Operation

**State machine**
- States are IDLE, FETCH and EXEC.
- IDLE → FETCH unconditionally.
- FETCH → EXEC when `imem_ack` = 1. Otherwise the FSM stays in FETCH.
- EXEC → FETCH unconditionally.
- `imem_req` = (state == FETCH) and `exec` = (state == EXEC). Both are Moore outputs.

**Sampling rules**
- Control inputs and `LT` are sampled only in EXEC and ignored in every other state.
- `imem_ack` is ignored outside FETCH.

**Next-PC priority in EXEC** (highest first; exactly one action per EXEC)
1. `ret_en`, RAS not empty: pop, and `pc` ← popped value.
2. `ret_en`, RAS empty: `pc` ← `pc`+1, `stk_unf` ← 1.
3. `call_en`, RAS not full: push `pc`+1, and `pc` ← `jmp_addr`.
4. `call_en`, RAS full: no push and RAS contents unchanged. `pc` ← `jmp_addr`, `stk_ovf` ← 1.
5. `jmp_en`: `pc` ← `jmp_addr`.
6. `br_en` and `LT`: `pc` ← `pc` + `br_offset`.
7. Otherwise: `pc` ← `pc`+1.

**Arithmetic and width rules**
- All PC arithmetic is modulo 2^n. Overflow bits are discarded.
- `pc`+1 at 2^n−1 wraps to 0.
- `br_offset` is added as an n-bit value, so negative offsets wrap correctly.
- A `br_en` with `LT` = 0 behaves as a plain increment.

**RAS**
- LIFO of DEPTH entries, each n bits wide, with a pointer count from 0 to DEPTH.
- Full means count == DEPTH; empty means count == 0.
- The RAS contents are not observable except through `ret_en`.

**Flags**
- `stk_ovf` and `stk_unf` are sticky and are cleared only by reset.

**Reset**
- While `nReset` = 0: state = IDLE, `pc` = 0, RAS count = 0.
- All outputs are 0 during reset: `imem_req`, `exec`, `stk_ovf`, `stk_unf` and `pc`.
- Reset asserted mid-FETCH or mid-EXEC aborts immediately, and the pending update is lost.

## Timing

- First rising edge after reset release: IDLE → FETCH, so `imem_req` = 1 from cycle 1.
- Minimum instruction period is 2 cycles: FETCH with `imem_ack` already high, then EXEC.
- Each additional cycle with `imem_ack` low adds one cycle of FETCH.
- `pc` is stable throughout FETCH and EXEC. It changes only on the edge that leaves EXEC, so the new `pc` is visible in the next FETCH cycle.
- RAS push, RAS pop and flag updates occur on the same edge as the `pc` update.
- No combinational path from any input to any output.

## Test plan

- **Reset and sequential fetch.** Stimulus: hold `nReset` low, release, tie `imem_ack` = 1, no controls asserted. Required: `pc` = 0 during reset; `imem_req` rises at cycle 1; `pc` steps 0, 1, 2, 3 every 2 cycles.
- **Fetch stall.** Stimulus: `imem_ack` low for 3 cycles in FETCH. Required: `imem_req` and `pc` are held, `exec` stays 0, and EXEC follows the first cycle with `imem_ack` high.
- **Branch with n=8.** Stimulus 1: `pc` = 0x10, `br_en` = 1, `LT` = 1, `br_offset` = 0xFC. Required: `pc` → 0x0C. Stimulus 2: same inputs with `LT` = 0. Required: `pc` → 0x11. Stimulus 3: `pc` = 0xFF with no control asserted. Required: `pc` wraps to 0x00.
- **Call/return nesting.** Stimulus: call to 0x40 from `pc` 0x05, call to 0x80 from 0x40, then ret, then ret. Required: `pc` sequence is 0x40, 0x80, 0x41, 0x06.
- **Overflow and underflow with DEPTH=4.** Stimulus: 5 consecutive calls. Required: the 5th call still jumps and `stk_ovf` = 1. Then 5 rets return the 4 stored addresses in LIFO order, and the 5th ret gives `pc`+1 with `stk_unf` = 1. Both flags stay high until reset.
- **Priority and mid-operation reset.** Stimulus 1: `ret_en`, `call_en`, `jmp_en` and `br_en` all high with `LT` = 1 and RAS non-empty. Required: only the pop occurs. Stimulus 2: assert `nReset` low during EXEC. Required: `pc` = 0, RAS empty and flags cleared immediately, with no clock edge needed.
